fu_sched: RTL

FU_SCHED -- requirements
Module: fu_sched

---
 rtl/fu_sched_pkg.sv | 43 ++++
 rtl/fu_sched_lane_alloc.sv | 50 +++++
 rtl/fu_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fu_sched_pkg.sv
// Shared types for the issue-slot / functional-unit scheduler:
// FU class bit positions, lane numbers, latency encodings and the slot bundle.
package fu_sched_pkg;

  localparam int NUM_FU   = 5;
  localparam int NUM_LANE = 4;
  localparam int RSV_W    = 16;

  // Bit position of each FU class inside a request mask; also the try order.
  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_BRU = 3'd1,
    FU_LSU = 3'd2,
    FU_MUL = 3'd3,
    FU_DIV = 3'd4
  } fu_class_e;

  // Fixed execution lanes.
  localparam logic [1:0] LANE_0 = 2'd0;  // ALU / BRU
  localparam logic [1:0] LANE_1 = 2'd1;  // ALU / MUL / DIV, shared writeback port
  localparam logic [1:0] LANE_2 = 2'd2;  // LSU
  localparam logic [1:0] LANE_3 = 2'd3;  // ALU

  // Issue-to-writeback latency of a single-cycle op; MUL/DIV are parameters.
  localparam int LAT_ALU = 1;

  // One issue-queue slot as seen by the lane picker.
  typedef struct packed {
    logic              valid;
    logic [NUM_FU-1:0] fu;
  } iss_bundle_t;

  // Reservation bit claimed by a lane1 op of latency lat (bit lat-1).
  function automatic logic [RSV_W-1:0] lat_onehot(input int lat);
    lat_onehot = RSV_W'(1) << (lat - 1);
  endfunction

  // Lane-taken mask contributed by one slot.
  function automatic logic [NUM_LANE-1:0] lane_mask(input logic hit, input logic [1:0] lane);
    lane_mask = hit ? (NUM_LANE'(1) << lane) : '0;
  endfunction

endpackage

// File: rtl/fu_sched_lane_alloc.sv
// Per-slot lane picker: given the lanes already taken by earlier slots and the
// lane1 writeback / divider state, choose the first feasible FU class and lane.
module lane_alloc
  import fu_sched_pkg::*;
(
  input  logic                en,
  input  iss_bundle_t         slot,
  input  logic [NUM_LANE-1:0] taken,
  input  logic                lsu_ready,
  input  logic                rsv_alu,
  input  logic                rsv_mul,
  input  logic                rsv_div,
  input  logic                div_busy,
  output logic                hit,
  output logic [1:0]          lane,
  output fu_class_e           cls
);

  // Classes are tried low to high; ALU prefers lanes 0, 3, then 1 so lane1
  // stays free for MUL/DIV whenever possible.
  always_comb begin
    hit  = 1'b0;
    lane = '0;
    cls  = FU_ALU;
    if (en && slot.valid) begin
      if (slot.fu[FU_ALU]) begin
        if (!taken[LANE_0]) begin
          hit = 1'b1; lane = LANE_0; cls = FU_ALU;
        end else if (!taken[LANE_3]) begin
          hit = 1'b1; lane = LANE_3; cls = FU_ALU;
        end else if (!taken[LANE_1] && !rsv_alu) begin
          hit = 1'b1; lane = LANE_1; cls = FU_ALU;
        end
      end
      if (!hit && slot.fu[FU_BRU] && !taken[LANE_0]) begin
        hit = 1'b1; lane = LANE_0; cls = FU_BRU;
      end
      if (!hit && slot.fu[FU_LSU] && lsu_ready && !taken[LANE_2]) begin
        hit = 1'b1; lane = LANE_2; cls = FU_LSU;
      end
      if (!hit && slot.fu[FU_MUL] && !taken[LANE_1] && !rsv_mul) begin
        hit = 1'b1; lane = LANE_1; cls = FU_MUL;
      end
      if (!hit && slot.fu[FU_DIV] && !taken[LANE_1] && !rsv_div && !div_busy) begin
        hit = 1'b1; lane = LANE_1; cls = FU_DIV;
      end
    end
  end

endmodule

// File: rtl/fu_sched.sv
// Issue scheduler: arbitrates iwd ready slots onto four fixed execution lanes,
// tracks lane1 writeback-port reservations and the non-pipelined divider.
module fu_sched
  import fu_sched_pkg::*;
#(
  parameter int iwd     = 4,
  parameter int mul_lat = 3,
  parameter int div_lat = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redir,
  input  logic [iwd-1:0]      req_valid,
  input  logic [iwd*5-1:0]    req_fu,
  input  logic                lsu_ready,
  output logic [4:0]          fu_ready,
  output logic [iwd-1:0]      grant,
  output logic [iwd*2-1:0]    lane,
  output logic                div_busy
);

  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_e;

  localparam logic [3:0] DIV_CNT0 = 4'(div_lat - 1);

  logic [RSV_W-1:0]    rsv;
  div_state_e          div_state;
  logic [3:0]          div_cnt;

  logic                issue_en;
  logic [NUM_LANE-1:0] taken_before [iwd];
  logic                pick_hit     [iwd];
  logic [1:0]          pick_lane    [iwd];
  fu_class_e           pick_cls     [iwd];

  logic [RSV_W-1:0]    l1_oh;
  logic                div_go;

  assign issue_en = ~rst & ~redir;

  assign fu_ready = {~div_busy & ~rsv[div_lat-1], ~rsv[mul_lat-1], lsu_ready, 1'b1, 1'b1};

  assign taken_before[0] = '0;

  for (genvar g = 0; g < iwd; g++) begin : g_slot
    iss_bundle_t slot;
    assign slot = '{valid: req_valid[g], fu: req_fu[g*NUM_FU +: NUM_FU]};

    lane_alloc u_alloc (
      .en        (issue_en),
      .slot      (slot),
      .taken     (taken_before[g]),
      .lsu_ready (lsu_ready),
      .rsv_alu   (rsv[LAT_ALU-1]),
      .rsv_mul   (rsv[mul_lat-1]),
      .rsv_div   (rsv[div_lat-1]),
      .div_busy  (div_busy),
      .hit       (pick_hit[g]),
      .lane      (pick_lane[g]),
      .cls       (pick_cls[g])
    );

    assign grant[g]         = pick_hit[g];
    assign lane[g*2 +: 2]   = pick_lane[g];

    if (g < iwd - 1) begin : g_chain
      assign taken_before[g+1] = taken_before[g] | lane_mask(pick_hit[g], pick_lane[g]);
    end
  end

  // Find the single lane1 grant (if any) and the writeback slot it claims.
  always_comb begin
    l1_oh  = '0;
    div_go = 1'b0;
    for (int i = 0; i < iwd; i++) begin
      if (pick_hit[i] && pick_lane[i] == LANE_1) begin
        case (pick_cls[i])
          FU_MUL:  l1_oh = lat_onehot(mul_lat);
          FU_DIV: begin
            l1_oh  = lat_onehot(div_lat);
            div_go = 1'b1;
          end
          default: l1_oh = lat_onehot(LAT_ALU);
        endcase
      end
    end
  end

  // Lane1 writeback reservations advance one cycle; a redirect drops them all.
  always_ff @(posedge clk) begin
    if (rst || redir) begin
      rsv <= '0;
    end else begin
      rsv <= (rsv | l1_oh) >> 1;
    end
  end

  // Divider occupancy: busy for div_lat-1 cycles after each DIV issue.
  always_ff @(posedge clk) begin
    if (rst || redir) begin
      div_state <= DIV_IDLE;
      div_cnt   <= '0;
      div_busy  <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (div_go) begin
            div_state <= DIV_BUSY;
            div_cnt   <= DIV_CNT0;
            div_busy  <= 1'b1;
          end
        end
        DIV_BUSY: begin
          div_cnt <= div_cnt - 4'd1;
          if (div_cnt == 4'd1) begin
            div_state <= DIV_IDLE;
            div_busy  <= 1'b0;
          end
        end
        default: begin
          div_state <= DIV_IDLE;
          div_cnt   <= '0;
          div_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
